// File: rtl/ascii_fmt_pkg.sv
// rtl/ascii_fmt_pkg.sv - shared FSM states, ASCII constants and nibble formatter for the hex streamer
package ascii_fmt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PFX0,
        PFX1,
        DIGIT,
        TERM
    } state_e;

    localparam logic [7:0] CHAR_0  = 8'h30;
    localparam logic [7:0] CHAR_UA = 8'h41;
    localparam logic [7:0] CHAR_LA = 8'h61;
    localparam logic [7:0] CHAR_X  = 8'h78;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_CR = 8'h0D;

    // Digit counters are sized for the largest supported value (16 nibbles).
    localparam int CNT_W = 5;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble, input logic lowercase);
        if (nibble < 4'd10) begin
            return CHAR_0 + {4'h0, nibble};
        end
        return (lowercase ? CHAR_LA : CHAR_UA) + {4'h0, nibble} - 8'd10;
    endfunction

endpackage

// File: rtl/lz_count.sv
// rtl/lz_count.sv - combinational count of leading zero nibbles in a NumDigits-nibble value
module lz_count
    import ascii_fmt_pkg::*;
#(
    parameter int NumDigits = 4
) (
    input  logic [4*NumDigits-1:0] value,
    output logic [CNT_W-1:0]       zeros
);

    logic found;

    always_comb begin
        zeros = '0;
        found = 1'b0;
        for (int i = NumDigits - 1; i >= 0; i--) begin
            if (!found) begin
                if (value[4*i +: 4] == 4'h0) begin
                    zeros = zeros + 5'd1;
                end else begin
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ascii_hex_streamer.sv
// rtl/ascii_hex_streamer.sv - streams a value as ASCII hex characters; ASCII_HEX_STREAMER_PREFIX_EN adds a "0x" prefix
module ascii_hex_streamer
    import ascii_fmt_pkg::*;
#(
    parameter int         NumDigits     = 4,
    parameter bit         SuppressZeros = 1'b0,
    parameter bit         TermEn        = 1'b1,
    parameter logic [7:0] TermChar      = 8'h0A,
    parameter bit         LowerCase     = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [4*NumDigits-1:0] value,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_data,
    output logic                   done
);

    localparam int W = 4 * NumDigits;

    state_e           state_q, state_d;
    logic [W-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] lz_raw;
    logic [CNT_W-1:0] skip;
    logic [W-1:0]     load_shift;
    logic [W-1:0]     shift_next;
    logic             xfer;

    lz_count #(
        .NumDigits(NumDigits)
    ) u_lz_count (
        .value(value),
        .zeros(lz_raw)
    );

    // An all-zero value still keeps its last nibble so "0" is emitted.
    always_comb begin
        skip = '0;
        if (SuppressZeros) begin
            skip = (lz_raw == CNT_W'(NumDigits)) ? CNT_W'(NumDigits - 1) : lz_raw;
        end
    end

    assign load_shift = value << {skip, 2'b00};
    assign shift_next = shift_q << 4;
    assign xfer       = out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = load_shift;
                    cnt_d   = CNT_W'(NumDigits) - skip;
`ifdef ASCII_HEX_STREAMER_PREFIX_EN
                    state_d    = PFX0;
                    out_data_d = CHAR_0;
`else
                    state_d    = DIGIT;
                    out_data_d = nibble_to_ascii(load_shift[W-1 -: 4], LowerCase);
`endif
                end
            end
`ifdef ASCII_HEX_STREAMER_PREFIX_EN
            PFX0: begin
                if (xfer) begin
                    state_d    = PFX1;
                    out_data_d = CHAR_X;
                end
            end
            PFX1: begin
                if (xfer) begin
                    state_d    = DIGIT;
                    out_data_d = nibble_to_ascii(shift_q[W-1 -: 4], LowerCase);
                end
            end
`endif
            DIGIT: begin
                if (xfer) begin
                    if (cnt_q == CNT_W'(1)) begin
                        shift_d = '0;
                        cnt_d   = '0;
                        if (TermEn) begin
                            state_d    = TERM;
                            out_data_d = TermChar;
                        end else begin
                            state_d    = IDLE;
                            out_data_d = 8'h00;
                            done_d     = 1'b1;
                        end
                    end else begin
                        shift_d    = shift_next;
                        cnt_d      = cnt_q - CNT_W'(1);
                        out_data_d = nibble_to_ascii(shift_next[W-1 -: 4], LowerCase);
                    end
                end
            end
            TERM: begin
                if (xfer) begin
                    state_d    = IDLE;
                    out_data_d = 8'h00;
                    done_d     = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                out_data_d = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            out_data_q <= 8'h00;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            done_q     <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q != IDLE);
    assign out_data  = out_data_q;
    assign done      = done_q;

endmodule
